// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: seven-segment message sequencer. A free-running
// prescaler paces static, blink, scroll-left and freeze display modes.
module seg_msg_scroller #(
    parameter int DIV_W   = 24,
    parameter int DIGITS  = 4,
    parameter int MSG_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          sw,
    input  logic [1:0]          mode,
    output logic [7*DIGITS-1:0] seg,
    output logic                tick
);

    localparam int PW   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int SUMW = PW + $clog2(DIGITS + 1) + 1;

    localparam logic [6:0] G_ZERO  = 7'b1000000;
    localparam logic [6:0] G_EIGHT = 7'b0000000;
    localparam logic [6:0] G_FIVE  = 7'b0010010;
    localparam logic [6:0] G_SEVEN = 7'b1011000;

    localparam logic [DIV_W-1:0] CNT_PRE  = ~DIV_W'(1);
    localparam logic [PW-1:0]    POS_LAST = PW'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        M_STATIC = 2'b00,
        M_BLINK  = 2'b01,
        M_SCROLL = 2'b10,
        M_FREEZE = 2'b11
    } mode_e;

    logic [DIV_W-1:0]    r_cnt;
    logic                r_tick;
    logic [6:0]          r_sym;
    logic [PW-1:0]       r_pos;
    logic                r_ph;
    logic [7*DIGITS-1:0] r_seg;

    mode_e               w_mode;
    logic [6:0]          w_sw_glyph;
    logic                w_sw_load;
    logic [PW-1:0]       w_pos_inc;
    logic [7*DIGITS-1:0] w_seg_nxt;

    // Slot index is widened so (pos + d) never overflows before the modulo.
    function automatic logic [6:0] slot_glyph(
        input logic [PW-1:0] p,
        input int            d,
        input logic [6:0]    s
    );
        logic [SUMW-1:0] slot;
        slot = (SUMW'(p) + SUMW'(d)) % SUMW'(MSG_LEN);
        return slot[0] ? s : G_ZERO;
    endfunction

    assign w_mode    = mode_e'(mode);
    assign w_sw_load = (sw != 2'b11) && (w_mode != M_FREEZE);
    assign w_pos_inc = (r_pos == POS_LAST) ? '0 : r_pos + PW'(1);

    always_comb begin
        w_sw_glyph = r_sym;
        unique case (sw)
            2'b00: w_sw_glyph = G_EIGHT;
            2'b01: w_sw_glyph = G_FIVE;
            2'b10: w_sw_glyph = G_SEVEN;
            2'b11: w_sw_glyph = r_sym;
        endcase
    end

    always_comb begin
        w_seg_nxt = '1;
        if (!r_ph) begin
            for (int d = 0; d < DIGITS; d++) begin
                w_seg_nxt[7*d +: 7] = slot_glyph(r_pos, d, r_sym);
            end
        end
    end

    // tick is registered one cycle early so it coincides with cnt all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_sym  <= G_EIGHT;
            r_pos  <= '0;
            r_ph   <= 1'b0;
            r_seg  <= '1;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_tick <= (r_cnt == CNT_PRE);
            r_seg  <= w_seg_nxt;
            if (w_sw_load) begin
                r_sym <= w_sw_glyph;
            end
            unique case (w_mode)
                M_STATIC: r_ph <= 1'b0;
                M_BLINK: begin
                    if (r_tick) begin
                        r_ph <= ~r_ph;
                    end
                end
                M_SCROLL: begin
                    r_ph <= 1'b0;
                    if (r_tick) begin
                        r_pos <= w_pos_inc;
                    end
                end
                M_FREEZE: ;
            endcase
        end
    end

    assign seg  = r_seg;
    assign tick = r_tick;

endmodule

// File: tb/tb_seg_msg_scroller.sv
// Bench for seg_msg_scroller: two instances (4 digits / 6 slots and
// 7 digits / 2 slots) checked against an arithmetic reference model.
module tb_seg_msg_scroller;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1011000;

    logic        clk  = 1'b0;
    logic        rst  = 1'b0;
    logic [1:0]  sw   = 2'b00;
    logic [1:0]  mode = 2'b00;
    logic [27:0] segA;
    logic [48:0] segB;
    logic        tickA;
    logic        tickB;

    int total = 0;
    int bad   = 0;

    int          m_n     = 0;
    int          m_posA  = 0;
    int          m_posB  = 0;
    int          m_dposA = 0;
    int          m_dposB = 0;
    logic        m_ph    = 1'b0;
    logic        m_dph   = 1'b0;
    logic [6:0]  m_sym   = G8;
    logic [27:0] m_segA  = '1;
    logic [48:0] m_segB  = '1;

    seg_msg_scroller #(.DIV_W(3), .DIGITS(4), .MSG_LEN(6)) dut_a (
        .clk(clk), .rst(rst), .sw(sw), .mode(mode),
        .seg(segA), .tick(tickA)
    );

    seg_msg_scroller #(.DIV_W(3), .DIGITS(7), .MSG_LEN(2)) dut_b (
        .clk(clk), .rst(rst), .sw(sw), .mode(mode),
        .seg(segB), .tick(tickB)
    );

    always #5 clk = ~clk;

    function automatic logic [48:0] win(int pos, int len, int nd, logic [6:0] s);
        logic [48:0] r;
        r = '1;
        for (int d = 0; d < nd; d++) begin
            r[7*d +: 7] = ((((pos + d) % len) % 2) == 1) ? s : G0;
        end
        return r;
    endfunction

    function automatic logic [6:0] sym_of(logic [1:0] s);
        case (s)
            2'b00:   return G8;
            2'b01:   return G5;
            default: return G7;
        endcase
    endfunction

    function automatic logic exp_tick();
        return (m_n % 8) == 7;
    endfunction

    // Reference model: message window and phase derived from step counts.
    always @(posedge clk) begin : model
        logic        tn;
        logic [48:0] wa;
        tn = ((m_n % 8) == 7);
        if (!rst) begin
            m_n = 0; m_posA = 0; m_posB = 0; m_ph = 1'b0; m_sym = G8;
            m_segA = '1; m_segB = '1; m_dposA = 0; m_dposB = 0; m_dph = 1'b0;
        end else begin
            wa      = win(m_posA, 6, 4, m_sym);
            m_segA  = m_ph ? '1 : wa[27:0];
            m_segB  = m_ph ? '1 : win(m_posB, 2, 7, m_sym);
            m_dposA = m_posA;
            m_dposB = m_posB;
            m_dph   = m_ph;
            if (mode != 2'b11 && sw != 2'b11) m_sym = sym_of(sw);
            case (mode)
                2'b00: m_ph = 1'b0;
                2'b01: if (tn) m_ph = !m_ph;
                2'b10: begin
                    m_ph = 1'b0;
                    if (tn) begin
                        m_posA = (m_posA + 1) % 6;
                        m_posB = (m_posB + 1) % 2;
                    end
                end
                default: ;
            endcase
            m_n++;
        end
    end

    task automatic test_reset();
        rst = 1'b0; sw = 2'b00; mode = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if (segA !== 28'hFFFFFFF || tickA !== 1'b0) begin
            bad++;
            $display("FAIL reset_blank seg=%h tick=%b exp seg=FFFFFFF tick=0", segA, tickA);
        end
        total++;
        if (segB !== {49{1'b1}}) begin
            bad++;
            $display("FAIL reset_blank_b seg=%h exp all ones", segB);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (segA !== {G8, G0, G8, G0}) begin
            bad++;
            $display("FAIL reset_window seg=%h exp=%h", segA, {G8, G0, G8, G0});
        end
        total++;
        if ({tickA, segA, tickB, segB} !== {exp_tick(), m_segA, exp_tick(), m_segB}) begin
            bad++;
            $display("FAIL reset_model a=%h b=%h exp a=%h b=%h", segA, segB, m_segA, m_segB);
        end
    endtask

    task automatic test_static();
        int ticks = 0;
        int last  = -1;
        int gaps_bad = 0;
        int changed = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            total++;
            if ({tickA, segA, tickB, segB} !== {exp_tick(), m_segA, exp_tick(), m_segB}) begin
                bad++;
                $display("FAIL static c=%0d seg=%h tick=%b exp seg=%h tick=%b",
                         c, segA, tickA, m_segA, exp_tick());
            end
            if (segA !== {G8, G0, G8, G0}) changed++;
            if (tickA === 1'b1) begin
                if (last >= 0 && c - last != 8) gaps_bad++;
                last = c;
                ticks++;
            end
        end
        total++;
        if (ticks != 3 || gaps_bad != 0) begin
            bad++;
            $display("FAIL static_tick_period ticks=%0d bad_gaps=%0d exp ticks=3 bad_gaps=0",
                     ticks, gaps_bad);
        end
        total++;
        if (changed != 0) begin
            bad++;
            $display("FAIL static_hold changed_cycles=%0d exp 0", changed);
        end
    endtask

    task automatic test_scroll();
        int hit5 = 0;
        sw = 2'b01; mode = 2'b10;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            total++;
            if ({tickA, segA, tickB, segB} !== {exp_tick(), m_segA, exp_tick(), m_segB}) begin
                bad++;
                $display("FAIL scroll c=%0d a=%h b=%h exp a=%h b=%h",
                         c, segA, segB, m_segA, m_segB);
            end
            if (m_dposA == 5 && !m_dph && m_n > 8) begin
                hit5++;
                total++;
                if (segA[6:0] !== G5 || segA[13:7] !== G0) begin
                    bad++;
                    $display("FAIL scroll_wrap_window d0=%b d1=%b exp d0=%b d1=%b",
                             segA[6:0], segA[13:7], G5, G0);
                end
            end
        end
        total++;
        if (hit5 == 0) begin
            bad++;
            $display("FAIL scroll_reach_pos5 hits=%0d exp >0", hit5);
        end
    endtask

    task automatic test_blink();
        int blanks = 0;
        int waited = 0;
        mode = 2'b01;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            total++;
            if ({tickA, segA, tickB, segB} !== {exp_tick(), m_segA, exp_tick(), m_segB}) begin
                bad++;
                $display("FAIL blink c=%0d a=%h exp=%h", c, segA, m_segA);
            end
            if (segA === 28'hFFFFFFF) blanks++;
        end
        total++;
        if (blanks < 8 || blanks > 32) begin
            bad++;
            $display("FAIL blink_alternate blank_cycles=%0d exp 8..32", blanks);
        end
        while (!m_dph && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!m_dph) begin
            bad++;
            $display("FAIL blink_wait_blank waited=%0d exp blank phase", waited);
        end
        mode = 2'b00;
        repeat (2) @(negedge clk);
        total++;
        if (segA === 28'hFFFFFFF || segA !== m_segA) begin
            bad++;
            $display("FAIL blink_exit seg=%h exp=%h", segA, m_segA);
        end
    endtask

    task automatic test_hold_freeze();
        int d_odd;
        int ticks = 0;
        logic [27:0] snap;
        mode = 2'b00; sw = 2'b10;
        repeat (3) @(negedge clk);
        sw = 2'b11;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({tickA, segA, tickB, segB} !== {exp_tick(), m_segA, exp_tick(), m_segB}) begin
                bad++;
                $display("FAIL hold c=%0d a=%h exp=%h", c, segA, m_segA);
            end
        end
        d_odd = ((m_dposA % 2) == 1) ? 0 : 1;
        total++;
        if (segA[7*d_odd +: 7] !== G7) begin
            bad++;
            $display("FAIL hold_sym digit%0d=%b exp=%b", d_odd, segA[7*d_odd +: 7], G7);
        end
        mode = 2'b11;
        snap = m_segA;
        for (int c = 0; c < 40; c++) begin
            sw = 2'($urandom_range(0, 3));
            @(negedge clk);
            total++;
            if ({tickA, segA, tickB, segB} !== {exp_tick(), m_segA, exp_tick(), m_segB}) begin
                bad++;
                $display("FAIL freeze c=%0d a=%h exp=%h", c, segA, m_segA);
            end
            if (tickA === 1'b1) ticks++;
            total++;
            if (segA !== snap) begin
                bad++;
                $display("FAIL freeze_const c=%0d seg=%h exp=%h", c, segA, snap);
            end
        end
        total++;
        if (ticks != 5) begin
            bad++;
            $display("FAIL freeze_ticks ticks=%0d exp=5", ticks);
        end
        mode = 2'b00; sw = 2'b11;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int waited = 0;
        mode = 2'b10; sw = 2'b11;
        @(negedge clk);
        while (!(exp_tick() && m_posA == 3) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!(exp_tick() && m_posA == 3) || tickA !== 1'b1) begin
            bad++;
            $display("FAIL midreset_find tick=%b pos=%0d exp tick=1 pos=3", tickA, m_posA);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (segA !== 28'hFFFFFFF || tickA !== 1'b0 || segB !== {49{1'b1}}) begin
            bad++;
            $display("FAIL midreset_blank seg=%h tick=%b exp seg=FFFFFFF tick=0", segA, tickA);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (segA !== {G8, G0, G8, G0}) begin
            bad++;
            $display("FAIL midreset_window seg=%h exp=%h", segA, {G8, G0, G8, G0});
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if ({tickA, segA, tickB, segB} !== {exp_tick(), m_segA, exp_tick(), m_segB}) begin
                bad++;
                $display("FAIL midreset_run c=%0d a=%h tick=%b exp a=%h tick=%b",
                         c, segA, tickA, m_segA, exp_tick());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            sw = 2'($urandom_range(0, 3));
            if (c % 16 == 0) mode = 2'($urandom_range(0, 3));
            @(negedge clk);
            total++;
            if ({tickA, segA, tickB, segB} !== {exp_tick(), m_segA, exp_tick(), m_segB}) begin
                bad++;
                $display("FAIL random c=%0d a=%h b=%h exp a=%h b=%h",
                         c, segA, segB, m_segA, m_segB);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_scroll();
        test_blink();
        test_hold_freeze();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_msg_scroller.md
# seg_msg_scroller

Parametrised multi-digit seven-segment message sequencer for the board's display bank. It builds a circular message from a switch-selected symbol alternating with '0'. An internal prescaler paces the display; per-mode the message is shown statically, blinked, scrolled left or frozen. It drives active-low segment lines for DIGITS digits directly from registers.

## Interface
- DIV_W, 24, prescaler width; one step tick every 2^DIV_W clk cycles (DIV_W ≥ 2)
- DIGITS, 4, number of seven-segment digits driven (≥ 1)
- MSG_LEN, 8, circular message length in slots (≥ 2)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; synchronous and active-low
- sw  input  2  symbol select: 00 = '8', 01 = '5', 10 = '7', 11 = hold last selection
- mode  input  2  00 static, 01 blink, 10 scroll left, 11 freeze
- seg  output  7*DIGITS  active-low segments, {g,f,e,d,c,b,a} per digit; digit 0 (leftmost) = seg[6:0], digit d = seg[7d+6:7d]
- tick  output  1  one-cycle pulse each prescaler wrap (for chaining and test)

## Operation
- Glyph codes (gfedcba, active-low): '0' = 1000000, '8' = 0000000, '5' = 0010010, '7' = 1011000, blank = 1111111.
- Symbol register sym: loaded every cycle from sw when sw ≠ 11; sw = 11 retains the current value. Reset value '8'.
- Message slot k (0..MSG_LEN-1): even k = '0', odd k = sym.
- Window offset pos, width $clog2(MSG_LEN), reset 0. Digit d displays slot (pos + d) mod MSG_LEN; the modulo is exact for any DIGITS, including DIGITS > MSG_LEN.
- Prescaler cnt, DIV_W bits, increments every cycle and wraps. tick = 1 in the cycle where cnt is all-ones.
- Blink phase ph, reset 0 (visible).
- Per-mode behaviour on a tick cycle:
  - static: pos and ph hold; ph forced to 0.
  - blink: ph toggles; pos holds.
  - scroll: pos ← pos+1, with MSG_LEN-1 wrapping to 0; ph forced to 0.
  - freeze: pos, ph and sym all hold. sw is ignored while mode = 11. The prescaler keeps running.
- Leaving blink mode returns ph to 0 on the next clock edge, whether or not it is a tick cycle.
- Mode changes do not reset pos or cnt.
- seg register: all digits blank when ph = 1, otherwise the windowed glyphs, computed from current sym, pos and ph.

## Timing
- Reset (rst = 0 at a rising edge):
  - cnt = 0, pos = 0, ph = 0, sym = '8'
  - seg = all ones (blank), tick = 0
- First edge after reset released: seg shows window pos = 0, i.e. digit 0 = '0', digit 1 = '8', and so on.
- Reset asserted mid-scroll or mid-blink takes effect on that edge and overrides any simultaneous tick.
- tick is registered: high for exactly one cycle, period 2^DIV_W cycles. The first tick occurs 2^DIV_W cycles after reset release.
- Latencies:
  - State updates (pos, ph) occur on the edge ending the tick cycle.
  - seg reflects pos/ph one edge later.
  - sw → seg: 2 edges (sym, then seg).
  - mode → behaviour: applies to the first tick sampled with the new value.
- A simultaneous tick and sw change is legal: the sym update and the pos step both occur on the same edge.

## Test plan
- Reset with DIV_W=3, DIGITS=4, MSG_LEN=6, mode=00, sw=00:
  - during reset: seg = 28'hFFFFFFF
  - after release: digits 0..3 = 1000000, 0000000, 1000000, 0000000
  - tick every 8 cycles; seg never changes in static mode.
- Scroll: mode=10, sw=01:
  - pos steps 0→1→…→5→0 on successive ticks (wrap check)
  - at pos = 5, digit 0 shows slot 5 = '5' and digit 1 shows slot 0 = '0'.
- Blink: mode=01:
  - seg alternates blank and window on each tick.
  - Switch to mode=00 while blank: seg visible within 2 edges, with no tick needed.
- Hold and freeze:
  - sw=10 then sw=11: odd slots stay '7' (1011000).
  - mode=11 with sw toggling: seg constant over 40 cycles while tick keeps pulsing.
- Mid-operation reset: assert rst=0 on a tick cycle at pos = 3. Next edge: pos = 0, sym = '8', seg blank, cnt = 0.
- Width sweep: DIGITS=7, MSG_LEN=2, with 5 scroll steps. Digit pattern alternates correctly and is the inverse at odd pos.
